// File: rtl/calc1_port_responder.sv
// calc1_port_responder: calc1 request/response device port (add, sub, shl, shr) with configurable exec latency.
// Define CALC1_DROP_CNT_EN to add the saturating drop_cnt output.
module calc1_port_responder #(
  parameter int EXEC_LAT = 2
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [0:3]  req_cmd_in,
  input  logic [0:31] req_data_in,
  output logic [0:1]  out_resp,
  output logic [0:31] out_data,
  output logic        busy
`ifdef CALC1_DROP_CNT_EN
  ,
  output logic [0:7]  drop_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, OP2, EXEC, RESP} state_t;
  state_t state, state_n;
  logic [0:3] cmd;
  logic [0:31] op1, op2, res_data, data_n;
  logic [0:1] res_resp, resp_n;
  logic [3:0] cnt;
  logic [32:0] sum;
  logic busy_n, accept;
  assign sum = {1'b0, op1} + {1'b0, op2};
  assign accept = (state == IDLE || state == RESP) && req_cmd_in != 4'd0;
  // Unknown opcodes and arithmetic faults both fall through to resp 2 / data 0
  always_comb begin
    res_resp = 2'd2;
    res_data = 32'd0;
    case (cmd)
      4'd1: if (!sum[32]) {res_resp, res_data} = {2'd1, sum[31:0]};
      4'd2: if (op2 <= op1) {res_resp, res_data} = {2'd1, op1 - op2};
      4'd5: {res_resp, res_data} = {2'd1, op1 << op2[27:31]};
      4'd6: {res_resp, res_data} = {2'd1, op1 >> op2[27:31]};
      default: ;
    endcase
  end
  always_comb begin
    state_n = state;
    resp_n = 2'd0;
    data_n = 32'd0;
    case (state)
      IDLE: state_n = accept ? OP2 : IDLE;
      OP2: state_n = EXEC;
      EXEC: state_n = cnt == 4'd0 ? RESP : EXEC;
      RESP: begin
        state_n = accept ? OP2 : IDLE;
        resp_n = res_resp;
        data_n = res_data;
      end
      default: state_n = IDLE;
    endcase
    busy_n = state_n == OP2 || state_n == EXEC;
  end
  always_ff @(posedge c_clk) begin
    if (!reset) begin
      state <= IDLE;
      out_resp <= 2'd0;
      out_data <= 32'd0;
      busy <= 1'b0;
      cmd <= 4'd0;
      op1 <= 32'd0;
      op2 <= 32'd0;
      cnt <= 4'd0;
    end else begin
      state <= state_n;
      out_resp <= resp_n;
      out_data <= data_n;
      busy <= busy_n;
      if (accept) begin
        cmd <= req_cmd_in;
        op1 <= req_data_in;
      end
      if (state == OP2) begin
        op2 <= req_data_in;
        cnt <= 4'(EXEC_LAT - 1);
      end else if (state == EXEC && cnt != 4'd0) cnt <= cnt - 4'd1;
    end
  end
`ifdef CALC1_DROP_CNT_EN
  logic drop;
  assign drop = (state == OP2 || state == EXEC) && req_cmd_in != 4'd0;
  always_ff @(posedge c_clk) begin
    if (!reset) drop_cnt <= 8'd0;
    else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end
`endif
endmodule

// File: tb/tb_calc1_port_responder.sv
// tb_calc1_port_responder: scoreboard bench for calc1_port_responder; the model tracks requests by edge number.
module tb_calc1_port_responder;
  localparam int L = 2;
  logic c_clk = 1'b0, reset = 1'b0;
  logic [0:3] req_cmd_in = 4'd0;
  logic [0:31] req_data_in = 32'd0;
  logic [0:1] out_resp;
  logic [0:31] out_data;
  logic busy;
`ifdef CALC1_DROP_CNT_EN
  logic [0:7] drop_cnt;
`endif
  always #5 c_clk = ~c_clk;
  calc1_port_responder #(.EXEC_LAT(L)) dut (
    .c_clk(c_clk),
    .reset(reset),
    .req_cmd_in(req_cmd_in),
    .req_data_in(req_data_in),
    .out_resp(out_resp),
    .out_data(out_data),
    .busy(busy)
`ifdef CALC1_DROP_CNT_EN
    ,
    .drop_cnt(drop_cnt)
`endif
  );
  typedef struct {int due; logic [0:1] resp; logic [0:31] data;} exp_t;
  exp_t q[$];
  exp_t m_e;
  int cyc = 0, free_at = 0, acc = -10, drops = 0, passed = 0, total = 0;
  bit pending = 0, mon_en = 0;
  logic [0:3] p_cmd;
  logic [0:31] p_op1;
  logic [0:3] tbl [5] = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd7};
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, cyc);
  endtask
  function automatic exp_t predict(int due, logic [0:3] c, logic [0:31] a, logic [0:31] b);
    exp_t e;
    logic [63:0] s;
    e.due = due;
    e.resp = 2'd2;
    e.data = 32'd0;
    s = {32'd0, a} + {32'd0, b};
    case (c)
      4'd1: if (s < 64'h1_0000_0000) begin e.resp = 2'd1; e.data = s[31:0]; end
      4'd2: if (b <= a) begin e.resp = 2'd1; e.data = a - b; end
      4'd5: begin e.resp = 2'd1; e.data = a << (b % 32); end
      4'd6: begin e.resp = 2'd1; e.data = a >> (b % 32); end
      default: ;
    endcase
    return e;
  endfunction
  // Model of what edge number cyc did with the inputs it sampled
  task automatic model(bit r, logic [0:3] c, logic [0:31] d);
    if (!r) begin
      q.delete();
      pending = 0;
      free_at = cyc + 1;
      drops = 0;
      return;
    end
    if (pending) begin
      q.push_back(predict(acc + 2 + L, p_cmd, p_op1, d));
      pending = 0;
    end
    if (c != 4'd0) begin
      if (cyc >= free_at) begin
        acc = cyc;
        free_at = cyc + 2 + L;
        pending = 1;
        p_cmd = c;
        p_op1 = d;
      end else if (drops < 255) drops++;
    end
  endtask
  task automatic drive(bit r, logic [0:3] c, logic [0:31] d);
    reset = r;
    req_cmd_in = c;
    req_data_in = d;
    @(posedge c_clk);
    #1;
    cyc++;
    model(r, c, d);
  endtask
  task automatic req(logic [0:3] c, logic [0:31] a, logic [0:31] b);
    drive(1'b1, c, a);
    drive(1'b1, 4'd0, b);
  endtask
  task automatic idle(int n);
    repeat (n) drive(1'b1, 4'd0, 32'd0);
  endtask
  always @(negedge c_clk) begin
    if (mon_en) begin
      m_e.due = cyc;
      m_e.resp = 2'd0;
      m_e.data = 32'd0;
      if (q.size() > 0 && q[0].due == cyc) m_e = q.pop_front();
      check("out_resp", 64'(out_resp), 64'(m_e.resp));
      check("out_data", 64'(out_data), 64'(m_e.data));
      check("busy", 64'(busy), 64'(cyc + 1 < free_at));
`ifdef CALC1_DROP_CNT_EN
      check("drop_cnt", 64'(drop_cnt), 64'(drops));
`endif
    end
  end
  initial begin
    logic [0:3] c;
    logic [0:31] d;
    bit r;
    drive(1'b0, 4'd0, 32'd0);
    mon_en = 1;
    drive(1'b0, 4'd0, 32'd0);
    req(4'd1, 32'h0000001A, 32'h00000005);
    idle(4);
    req(4'd1, 32'hFFFFFFFF, 32'h00000001);
    idle(4);
    req(4'd2, 32'h00000005, 32'h0000000A);
    idle(4);
    req(4'd2, 32'hD2ACA01F, 32'hC403C462);
    idle(4);
    req(4'd2, 32'h12345678, 32'h12345678);
    idle(4);
    req(4'd5, 32'hCDE1056E, 32'h00000101);
    idle(4);
    req(4'd6, 32'hCDE1056E, 32'h00000101);
    idle(4);
    req(4'd6, 32'hCDE1056E, 32'h00000000);
    idle(4);
    req(4'd7, 32'h2309ABEF, 32'h332200FF);
    idle(4);
    req(4'd1, 32'h10, 32'h20);
    drive(1'b1, 4'd1, 32'h3);
    drive(1'b1, 4'd0, 32'h0);
    req(4'd2, 32'h100, 32'h1);
    idle(6);
    req(4'd1, 32'h1, 32'h2);
    drive(1'b0, 4'd0, 32'h0);
    idle(6);
    req(4'd1, 32'h7, 32'h8);
    idle(5);
    repeat (400) drive(1'b1, 4'($urandom_range(1, 15)), $urandom);
    idle(6);
    repeat (3000) begin
      r = $urandom_range(0, 199) != 0;
      c = $urandom_range(0, 2) != 0 ? 4'd0 :
          $urandom_range(0, 3) != 0 ? tbl[$urandom_range(0, 4)] : 4'($urandom_range(1, 15));
      d = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 64)) : $urandom;
      drive(r, c, d);
    end
    idle(10);
    mon_en = 0;
    check("drain", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/calc1_port_responder.md
Name: calc1_port_responder

Overview:
- Single-port responder for the calc1 request/response protocol: the device end that requestors drive.
- Captures a two-cycle request (command plus operand 1, then operand 2), executes add, subtract, shift-left or shift-right, and returns one response cycle.
- Serves as the lightweight standalone model and reference port for calc1_top integration.
- Used behind each requestor port when full calc1_top arbitration is not needed.

Parameters:
- EXEC_LAT, 2, cycles spent in EXEC before the response; legal range 1..15.

Ports:
- c_clk  input  1  single clock; all logic on its rising edge.
- reset  input  1  synchronous, active-low reset.
- req_cmd_in  input  [0:3]  0=none, 1=add, 2=sub, 5=shift left, 6=shift right, other nonzero values invalid.
- req_data_in  input  [0:31]  operand 1 in the command cycle, operand 2 in the following cycle; bit 0 is the MSB.
- out_resp  output  [0:1]  0=none, 1=success, 2=invalid command or overflow/underflow, 3=never driven.
- out_data  output  [0:31]  result; valid only while out_resp=1, otherwise 0.
- busy  output  1  high while a request is in flight; new commands are not accepted.

Behaviour:
- Reset (reset=0 at a clock edge):
  - state=IDLE; out_resp=0, out_data=0, busy=0.
  - Any in-flight request is discarded and no response is ever issued for it.
- All outputs are registered.
- States: IDLE, OP2, EXEC, RESP.
- IDLE:
  - req_cmd_in!=0 at edge T: latch cmd and op1=req_data_in, go to OP2, busy=1 from T+1.
  - req_cmd_in=0: stay in IDLE.
- OP2 (edge T+1):
  - Latch op2=req_data_in. req_cmd_in is ignored.
  - Load the latency counter with EXEC_LAT-1 and go to EXEC.
- EXEC:
  - Decrement the counter each cycle.
  - At 0, compute the result and go to RESP.
  - Total EXEC cycles = EXEC_LAT.
- RESP:
  - out_resp/out_data are valid for exactly one cycle, first visible after edge T+2+EXEC_LAT.
  - Next cycle: out_resp=0, out_data=0.
  - busy=0 in the RESP cycle, so a command may be presented in that cycle. It is accepted (RESP->OP2), giving back-to-back service.
- Commands presented while in OP2 or EXEC are dropped silently: no response, and the state is unaffected.
- Arithmetic (unsigned, 32-bit):
  - add: 33-bit sum; carry-out=1 gives resp 2, data 0; otherwise resp 1 with the sum.
  - sub: op2>op1 gives resp 2, data 0; otherwise resp 1 with op1-op2; equal operands give resp 1, data 0.
  - shift left: op1 << op2[27:31], zero fill, always resp 1.
  - shift right: logical op1 >> op2[27:31], zero fill, always resp 1; op2[0:26] is ignored.
  - Invalid cmd (3,4,7..15): still consumes the OP2 cycle and full latency, then resp 2, data 0.
- Reset asserted in any state returns to IDLE at that edge. The first request after reset release is accepted on the first edge with reset=1.

Optional Feature:
- Macro CALC1_DROP_CNT_EN.
- Defined:
  - Adds output drop_cnt [0:7], an 8-bit saturating count of commands dropped in OP2/EXEC.
  - Saturates at 255. Cleared by reset. Increments once per cycle with a dropped nonzero cmd.
- Undefined:
  - No drop_cnt port and no counter logic.
  - Dropping behaviour is otherwise identical.

Test Plan:
- Reset then add, EXEC_LAT=2: cmd=1 data=0x0000001A, next cycle data=0x00000005 -> out_resp=1, out_data=0x0000001F exactly 4 cycles after the command edge, for one cycle, then 0/0.
- Add overflow: 0xFFFFFFFF + 0x00000001 -> resp 2, data 0. Sub underflow: 0x00000005 - 0x0000000A -> resp 2, data 0. Sub 0xD2ACA01F - 0xC403C462 -> resp 1, data 0x0EA8DBBD.
- Shifts: cmd=5, 0xCDE1056E by 0x00000101 -> resp 1, 0x9BC20ADC. cmd=6, same operands -> 0x66F082B7. cmd=6 with op2=0 -> 0xCDE1056E.
- Invalid: cmd=7 data=0x2309ABEF, then 0x332200FF -> resp 2, data 0 at normal latency.
- Busy/drop: cmd=1 issued in the EXEC cycle of an earlier request -> only the first response appears; drop_cnt=1 when CALC1_DROP_CNT_EN is defined. A command issued in the RESP cycle is accepted and answered.
- Reset mid-EXEC: reset low one cycle during EXEC -> outputs 0, busy 0, no response ever appears. A following request completes normally.
